// File: rtl/toggle_rx.sv
// Receiver for a two-phase (toggle) request/acknowledge link: captures one word per request
// toggle, offers it on valid/ready, returns an ack toggle. Define TOGGLE_RX_SYNC_EN for a 2-flop request synchroniser.
module toggle_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              ack_tgl,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic              overrun
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic              req_sync;
  logic              req_prev_q;
  logic              req_edge;

  logic              state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;

`ifdef TOGGLE_RX_SYNC_EN
  logic req_s1_q;
  logic req_s2_q;

  // Sender runs on another clock: resolve metastability before edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
    end else begin
      req_s1_q <= req_tgl;
      req_s2_q <= req_s1_q;
    end
  end

  assign req_sync = req_s2_q;
`else
  assign req_sync = req_tgl;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_prev_q <= 1'b0;
    end else begin
      req_prev_q <= req_sync;
    end
  end

  assign req_edge = req_sync ^ req_prev_q;

  // A toggle seen while a word is pending is dropped and only flagged.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (req_edge) begin
          ovr_d = 1'b1;
        end
        if (ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign ack_tgl  = ack_q;
  assign evt_cnt  = cnt_q;
  assign overrun  = ovr_q;

endmodule
